// File: rtl/cjoin2_cache_sync_if.sv
// Handshake bundle between two upstream producers, the join, and the next stage.
// The join itself connects through the slave modport.
interface cjoin2_cache_sync_if #(
   parameter int unsigned DATA_W = 32
);
   logic                  i_drive0;
   logic [DATA_W-1:0]     i_data0;
   logic                  o_free0;
   logic                  i_drive1;
   logic [DATA_W-1:0]     i_data1;
   logic                  o_free1;
   logic                  o_driveNext;
   logic [2*DATA_W-1:0]   o_data;
   logic                  i_freeNext;
   logic                  o_busy;
   logic                  o_err;

   modport master (
      output i_drive0, i_data0, i_drive1, i_data1, i_freeNext,
      input  o_free0, o_free1, o_driveNext, o_data, o_busy, o_err
   );

   modport slave (
      input  i_drive0, i_data0, i_drive1, i_data1, i_freeNext,
      output o_free0, o_free1, o_driveNext, o_data, o_busy, o_err
   );
endinterface

// File: rtl/cjoin2_cache_sync.sv
// Two-way join: collects one drive from each producer, issues a combined drive, and
// returns a simultaneous free to both producers FREE_DELAY cycles after the next stage frees.
module cjoin2_cache_sync #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FREE_DELAY = 6
) (
   input logic                clk,
   input logic                rstn,
   cjoin2_cache_sync_if.slave bus
);

   typedef enum logic [1:0] {StCollect, StWaitFree, StDelay} stateT;

   localparam logic [7:0] CntInit = 8'(FREE_DELAY);

   stateT             state;
   logic              arrived0;
   logic              arrived1;
   logic [DATA_W-1:0] data0Q;
   logic [DATA_W-1:0] data1Q;
   logic [7:0]        cnt;

   logic              take0;
   logic              take1;
   logic              pairDone;
   logic [DATA_W-1:0] nxt0;
   logic [DATA_W-1:0] nxt1;

   always_comb begin
      take0    = bus.i_drive0 & ~arrived0;
      take1    = bus.i_drive1 & ~arrived1;
      pairDone = (arrived0 | take0) & (arrived1 | take1);
      nxt0     = take0 ? bus.i_data0 : data0Q;
      nxt1     = take1 ? bus.i_data1 : data1Q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= StCollect;
         arrived0        <= 1'b0;
         arrived1        <= 1'b0;
         data0Q          <= '0;
         data1Q          <= '0;
         cnt             <= '0;
         bus.o_free0     <= 1'b0;
         bus.o_free1     <= 1'b0;
         bus.o_driveNext <= 1'b0;
         bus.o_data      <= '0;
         bus.o_busy      <= 1'b0;
         bus.o_err       <= 1'b0;
      end else begin
         bus.o_driveNext <= 1'b0;
         bus.o_free0     <= 1'b0;
         bus.o_free1     <= 1'b0;
         case (state)
            StCollect: begin
               if (take0) begin
                  arrived0 <= 1'b1;
                  data0Q   <= bus.i_data0;
               end
               if (take1) begin
                  arrived1 <= 1'b1;
                  data1Q   <= bus.i_data1;
               end
               // A repeated drive keeps the first word; only the flag records the violation.
               if ((bus.i_drive0 & arrived0) | (bus.i_drive1 & arrived1) | bus.i_freeNext) begin
                  bus.o_err <= 1'b1;
               end
               if (pairDone) begin
                  bus.o_driveNext <= 1'b1;
                  bus.o_data      <= {nxt1, nxt0};
                  bus.o_busy      <= 1'b1;
                  state           <= StWaitFree;
               end else begin
                  bus.o_busy <= arrived0 | arrived1 | take0 | take1;
               end
            end
            StWaitFree: begin
               if (bus.i_drive0 | bus.i_drive1) bus.o_err <= 1'b1;
               if (bus.i_freeNext) begin
                  state <= StDelay;
                  if (FREE_DELAY == 0) begin
                     bus.o_free0 <= 1'b1;
                     bus.o_free1 <= 1'b1;
                     cnt         <= '0;
                  end else begin
                     cnt <= CntInit;
                  end
               end
            end
            StDelay: begin
               if (bus.i_drive0 | bus.i_drive1 | bus.i_freeNext) bus.o_err <= 1'b1;
               // cnt == 0 marks the free cycle itself; leave DELAY only once it has passed.
               if (cnt == 8'd0) begin
                  arrived0   <= 1'b0;
                  arrived1   <= 1'b0;
                  bus.o_busy <= 1'b0;
                  state      <= StCollect;
               end else begin
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     bus.o_free0 <= 1'b1;
                     bus.o_free1 <= 1'b1;
                  end
               end
            end
            default: state <= StCollect;
         endcase
      end
   end

endmodule

// File: tb/tb_cjoin2_cache_sync.sv
// Scoreboard bench: two joins (FREE_DELAY 6 and 0) driven by directed vectors; monitors
// pop expected drive/free events and compare cycle, kind and held data.
module tb_cjoin2_cache_sync;

   typedef struct {
      bit          isFree;
      int          cycle;
      logic [63:0] data;
   } evT;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   evT   qA[$];
   evT   qB[$];

   cjoin2_cache_sync_if #(.DATA_W(32)) busA ();
   cjoin2_cache_sync_if #(.DATA_W(32)) busB ();

   cjoin2_cache_sync #(.DATA_W(32), .FREE_DELAY(6)) dutA (
      .clk  (clk),
      .rstn (rstn),
      .bus  (busA)
   );

   cjoin2_cache_sync #(.DATA_W(32), .FREE_DELAY(0)) dutB (
      .clk  (clk),
      .rstn (rstn),
      .bus  (busB)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic waitTo(input int n);
      while (cyc != n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic stim(input bit selB, input bit d0, input bit d1, input bit fn,
                       input logic [31:0] x0, input logic [31:0] x1);
      if (!selB) begin
         busA.i_drive0 = d0; busA.i_drive1 = d1; busA.i_freeNext = fn;
         busA.i_data0 = x0;  busA.i_data1 = x1;
      end else begin
         busB.i_drive0 = d0; busB.i_drive1 = d1; busB.i_freeNext = fn;
         busB.i_data0 = x0;  busB.i_data1 = x1;
      end
      @(posedge clk);
      #1;
      busA.i_drive0 = 1'b0; busA.i_drive1 = 1'b0; busA.i_freeNext = 1'b0;
      busB.i_drive0 = 1'b0; busB.i_drive1 = 1'b0; busB.i_freeNext = 1'b0;
      busA.i_data0 = '0; busA.i_data1 = '0; busB.i_data0 = '0; busB.i_data1 = '0;
   endtask

   task automatic expectEv(input bit selB, input bit isFree, input int c, input logic [63:0] d);
      evT e;
      e.isFree = isFree;
      e.cycle  = c;
      e.data   = d;
      if (!selB) qA.push_back(e);
      else qB.push_back(e);
   endtask

   task automatic monitorOne(input bit selB, input logic dn, input logic f0, input logic f1,
                             input logic [63:0] d);
      evT    e;
      string tag;
      tag = selB ? "B" : "A";
      if (dn || f0 || f1) begin
         if ((selB && qB.size() == 0) || (!selB && qA.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s.unexpected: got dn=%b f0=%b f1=%b expected none (cycle %0d)",
                     tag, dn, f0, f1, cyc);
         end else begin
            e = selB ? qB.pop_front() : qA.pop_front();
            check({tag, ".kind"}, {61'd0, dn, f0, f1}, e.isFree ? 64'd3 : 64'd4);
            check({tag, ".cycle"}, 64'(cyc), 64'(e.cycle));
            check({tag, ".data"}, d, e.data);
         end
      end
   endtask

   always @(negedge clk) monitorOne(1'b0, busA.o_driveNext, busA.o_free0, busA.o_free1, busA.o_data);
   always @(negedge clk) monitorOne(1'b1, busB.o_driveNext, busB.o_free0, busB.o_free1, busB.o_data);

   initial begin
      busA.i_drive0 = 1'b0; busA.i_drive1 = 1'b0; busA.i_freeNext = 1'b0;
      busB.i_drive0 = 1'b0; busB.i_drive1 = 1'b0; busB.i_freeNext = 1'b0;
      busA.i_data0 = '0; busA.i_data1 = '0; busB.i_data0 = '0; busB.i_data1 = '0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Reset state
      waitTo(5);
      check("A.resetFlags", {59'd0, busA.o_driveNext, busA.o_free0, busA.o_free1,
                             busA.o_busy, busA.o_err}, 64'd0);
      check("A.resetData", busA.o_data, 64'd0);
      check("B.resetFlags", {59'd0, busB.o_driveNext, busB.o_free0, busB.o_free1,
                             busB.o_busy, busB.o_err}, 64'd0);

      // Simultaneous arrival, then free path with FREE_DELAY 6
      waitTo(10);
      expectEv(1'b0, 1'b0, 11, 64'h5A5A5A5A_A5A5A5A5);
      stim(1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
      waitTo(13);
      expectEv(1'b0, 1'b1, 20, 64'h5A5A5A5A_A5A5A5A5);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(20);
      check("A.busyInFree", {63'd0, busA.o_busy}, 64'd1);
      waitTo(21);
      check("A.busyAfterFree", {63'd0, busA.o_busy}, 64'd0);

      // Staggered arrival
      waitTo(28);
      check("A.busyIdle", {63'd0, busA.o_busy}, 64'd0);
      stim(1'b0, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'h0);
      check("A.busyOneArrived", {63'd0, busA.o_busy}, 64'd1);
      waitTo(34);
      expectEv(1'b0, 1'b0, 35, 64'h22222222_11111111);
      stim(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h22222222);
      waitTo(45);
      expectEv(1'b0, 1'b1, 52, 64'h22222222_11111111);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(53);
      check("A.busyAfterFree2", {63'd0, busA.o_busy}, 64'd0);
      check("A.errClean", {63'd0, busA.o_err}, 64'd0);

      // Protocol violations
      waitTo(56);
      stim(1'b0, 1'b1, 1'b0, 1'b0, 32'h33333333, 32'h0);
      stim(1'b0, 1'b1, 1'b0, 1'b0, 32'h44444444, 32'h0);
      check("A.errDoubleDrive", {63'd0, busA.o_err}, 64'd1);
      check("A.dataAfterDouble", busA.o_data, 64'h22222222_11111111);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      check("A.errFreeInCollect", {63'd0, busA.o_err}, 64'd1);
      expectEv(1'b0, 1'b0, 60, 64'h55555555_33333333);
      stim(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h55555555);
      waitTo(62);
      stim(1'b0, 1'b1, 1'b0, 1'b0, 32'h66666666, 32'h0);
      check("A.errDriveInWait", {63'd0, busA.o_err}, 64'd1);
      check("A.dataAfterWaitDrive", busA.o_data, 64'h55555555_33333333);
      waitTo(65);
      expectEv(1'b0, 1'b1, 72, 64'h55555555_33333333);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(67);
      stim(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h77777777);
      waitTo(68);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(74);
      check("A.errSticky", {63'd0, busA.o_err}, 64'd1);
      check("A.dataAfterDelay", busA.o_data, 64'h55555555_33333333);

      // Reset in the middle of DELAY
      waitTo(82);
      expectEv(1'b0, 1'b0, 83, 64'h88888888_77777777);
      stim(1'b0, 1'b1, 1'b1, 1'b0, 32'h77777777, 32'h88888888);
      waitTo(84);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(88);
      #2 rstn = 1'b0;
      #1;
      check("A.asyncResetFlags", {59'd0, busA.o_driveNext, busA.o_free0, busA.o_free1,
                                  busA.o_busy, busA.o_err}, 64'd0);
      check("A.asyncResetData", busA.o_data, 64'd0);
      waitTo(89);
      rstn = 1'b1;
      waitTo(95);
      expectEv(1'b0, 1'b0, 96, 64'hAAAAAAAA_99999999);
      stim(1'b0, 1'b1, 1'b1, 1'b0, 32'h99999999, 32'hAAAAAAAA);
      waitTo(98);
      expectEv(1'b0, 1'b1, 105, 64'hAAAAAAAA_99999999);
      stim(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(106);
      check("A.busyAfterReset", {63'd0, busA.o_busy}, 64'd0);
      check("A.errAfterReset", {63'd0, busA.o_err}, 64'd0);

      // FREE_DELAY 0: immediate free and back-to-back transaction
      waitTo(112);
      expectEv(1'b1, 1'b0, 113, 64'hCCCCCCCC_BBBBBBBB);
      stim(1'b1, 1'b1, 1'b1, 1'b0, 32'hBBBBBBBB, 32'hCCCCCCCC);
      waitTo(130);
      expectEv(1'b1, 1'b1, 131, 64'hCCCCCCCC_BBBBBBBB);
      stim(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(132);
      expectEv(1'b1, 1'b0, 133, 64'hEEEEEEEE_DDDDDDDD);
      stim(1'b1, 1'b1, 1'b1, 1'b0, 32'hDDDDDDDD, 32'hEEEEEEEE);
      waitTo(135);
      expectEv(1'b1, 1'b1, 136, 64'hEEEEEEEE_DDDDDDDD);
      stim(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      waitTo(137);
      check("B.busyAfterFree", {63'd0, busB.o_busy}, 64'd0);
      check("B.errClean", {63'd0, busB.o_err}, 64'd0);

      waitTo(145);
      check("A.pendingEvents", 64'(qA.size()), 64'd0);
      check("B.pendingEvents", 64'(qB.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
